// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the multi-cycle RV32I control path
// Holds the control FSM state enum, ALUOp encodings shared with ALU_Control,
// RV32I opcode constants, datapath select encodings and the imm_src decoder.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Immediate format from the opcode; unknown opcodes fall back to I-type.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch condition evaluation from funct3 and ALU compare flags
// Ports:
//   funct3     in  branch type from IR[14:12]
//   alu_zero   in  rs1 - rs2 == 0
//   alu_lt     in  signed rs1 < rs2
//   alu_ltu    in  unsigned rs1 < rs2
//   taken      out branch condition holds
//   bad_funct3 out funct3 is not a defined branch (010/011)
module branch_resolve (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multi-cycle RV32I core
// Optional feature macro: MEM_WAIT_EN (honour mem_ready; otherwise it is treated as 1).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   opcode, funct3         IR fields
//   alu_zero/lt/ltu        ALU compare flags for branch resolution
//   mem_ready              memory completes the current access this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write   datapath strobes/selects
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src    datapath mux selects, ALUOp
//   illegal                one-cycle pulse on unsupported opcode or branch funct3
module multicycle_control
    import cpu_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal
);

    state_t state_q;
    state_t state_d;
    logic   ready;
    logic   br_taken;
    logic   br_bad;
    logic   mem_write_raw;
    logic   reg_write_raw;

`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready            = 1'b1;
`endif

    branch_resolve u_branch_resolve (
        .funct3     (funct3),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu),
        .taken      (br_taken),
        .bad_funct3 (br_bad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign imm_src = imm_src_of(opcode);

    // Architectural writes are suppressed while reset is asserted so that a
    // reset landing mid-access never leaves a half-issued store or rd write.
    assign mem_write = mem_write_raw & rst_n;
    assign reg_write = reg_write_raw & rst_n;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write      = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        illegal       = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) state_d = DECODE;
            end
            DECODE: begin
                // Speculatively form OldPC + imm so branch/JAL targets land in ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src    = RES_MEM;
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_RTYPE;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ITYPE;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pc_write  = br_taken;
                illegal   = br_bad;
                state_d   = FETCH;
            end
            JAL: begin
                // PC takes the target held in ALUOut; OldPC + 4 goes on to rd.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = JAL;
            end
            LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                state_d   = ALUWB;
            end
            AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
    import cpu_pkg::*;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, alu_ltu, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(dut.state_q), 32'(exp));
    endtask

    // Runs FETCH and DECODE for the current opcode with mem_ready=1.
    task automatic fetch_decode(input string tag);
        check_state({tag, "_fetch"}, FETCH);
        step();
        check_state({tag, "_decode"}, DECODE);
        step();
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic lt, input logic ltu, input logic exp_pc,
                              input logic exp_ill);
        opcode = OP_BRANCH;
        funct3 = f3;
        #1;
        check({tag, "_imm_src"}, 32'(imm_src), 32'(IMM_B));
        fetch_decode(tag);
        alu_zero = z;
        alu_lt   = lt;
        alu_ltu  = ltu;
        #1;
        check_state({tag, "_state"}, BRANCH);
        check({tag, "_alu_op"}, 32'(alu_op), 32'(ALUOP_SUB));
        check({tag, "_pc_write"}, 32'(pc_write), 32'(exp_pc));
        check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        step();
        check_state({tag, "_back"}, FETCH);
        alu_zero = 1'b0;
        alu_lt   = 1'b0;
        alu_ltu  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = OP_RTYPE;
        funct3    = 3'b000;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        alu_ltu   = 1'b0;
        mem_ready = 1'b1;
        step();
        step();

        // Reset outputs
        check_state("rst_state", FETCH);
        check("rst_alu_src_a", 32'(alu_src_a), 32'(2'b00));
        check("rst_alu_src_b", 32'(alu_src_b), 32'(2'b10));
        check("rst_result_src", 32'(result_src), 32'(2'b10));
        check("rst_alu_op", 32'(alu_op), 32'(2'b00));
        check("rst_mem_write", 32'(mem_write), 32'(1'b0));
        check("rst_reg_write", 32'(reg_write), 32'(1'b0));
        check("rst_illegal", 32'(illegal), 32'(1'b0));
        check("rst_ir_write_r1", 32'(ir_write), 32'(1'b1));
        mem_ready = 1'b0;
        #1;
        check("rst_ir_write_r0", 32'(ir_write), 32'(WAIT_EN ? 1'b0 : 1'b1));
        check("rst_pc_write_r0", 32'(pc_write), 32'(WAIT_EN ? 1'b0 : 1'b1));

        // FETCH with mem_ready low: holds only when waits are honoured
        rst_n = 1'b1;
        step();
        check_state("fetch_wait", WAIT_EN ? FETCH : DECODE);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // add x3,x1,x2 (0x002081B3)
        opcode = 7'b0110011;
        funct3 = 3'b000;
        #1;
        check("add_fetch_ir_write", 32'(ir_write), 32'(1'b1));
        check("add_fetch_pc_write", 32'(pc_write), 32'(1'b1));
        check("add_fetch_adr_src", 32'(adr_src), 32'(1'b0));
        check_state("add_fetch", FETCH);
        step();
        check_state("add_decode", DECODE);
        check("add_dec_src_a", 32'(alu_src_a), 32'(2'b01));
        check("add_dec_src_b", 32'(alu_src_b), 32'(2'b01));
        step();
        check_state("add_execr", EXECR);
        check("add_execr_alu_op", 32'(alu_op), 32'(2'b10));
        check("add_execr_src_a", 32'(alu_src_a), 32'(2'b10));
        check("add_execr_src_b", 32'(alu_src_b), 32'(2'b00));
        check("add_execr_reg_write", 32'(reg_write), 32'(1'b0));
        step();
        check_state("add_aluwb", ALUWB);
        check("add_aluwb_reg_write", 32'(reg_write), 32'(1'b1));
        check("add_aluwb_result_src", 32'(result_src), 32'(2'b00));
        step();
        check_state("add_done", FETCH);

        // lw with 3 wait cycles in MEMREAD
        opcode = 7'b0000011;
        funct3 = 3'b010;
        #1;
        check("lw_imm_src", 32'(imm_src), 32'(IMM_I));
        fetch_decode("lw");
        check_state("lw_memadr", MEMADR);
        check("lw_memadr_src_a", 32'(alu_src_a), 32'(2'b10));
        check("lw_memadr_src_b", 32'(alu_src_b), 32'(2'b01));
        step();
        if (WAIT_EN) begin
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b0;
                #1;
                check_state("lw_memread_wait", MEMREAD);
                check("lw_wait_reg_write", 32'(reg_write), 32'(1'b0));
                step();
            end
        end
        mem_ready = 1'b1;
        #1;
        check_state("lw_memread", MEMREAD);
        check("lw_memread_adr_src", 32'(adr_src), 32'(1'b1));
        check("lw_memread_reg_write", 32'(reg_write), 32'(1'b0));
        step();
        check_state("lw_memwb", MEMWB);
        check("lw_memwb_reg_write", 32'(reg_write), 32'(1'b1));
        check("lw_memwb_result_src", 32'(result_src), 32'(2'b01));
        step();
        check_state("lw_done", FETCH);

        // Branches
        run_branch("beq_z1",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_branch("bne_z1",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_branch("bltu_1",  3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_branch("bge_lt0", 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_branch("blt_lt1", 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_branch("bad_f3",  3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Illegal opcode 0x7F
        opcode = 7'h7F;
        funct3 = 3'b000;
        #1;
        check("ill_fetch_illegal", 32'(illegal), 32'(1'b0));
        step();
        check_state("ill_decode", DECODE);
        check("ill_decode_illegal", 32'(illegal), 32'(1'b1));
        step();
        check_state("ill_back", FETCH);
        check("ill_after_illegal", 32'(illegal), 32'(1'b0));

        // jalr
        opcode = 7'b1100111;
        #1;
        fetch_decode("jalr");
        check_state("jalr_jalr", JALR);
        check("jalr_src_a", 32'(alu_src_a), 32'(2'b10));
        check("jalr_src_b", 32'(alu_src_b), 32'(2'b01));
        check("jalr_pc_write", 32'(pc_write), 32'(1'b0));
        step();
        check_state("jalr_jal", JAL);
        check("jal_pc_write", 32'(pc_write), 32'(1'b1));
        check("jal_src_a", 32'(alu_src_a), 32'(2'b01));
        check("jal_src_b", 32'(alu_src_b), 32'(2'b10));
        check("jal_result_src", 32'(result_src), 32'(2'b00));
        step();
        check_state("jalr_aluwb", ALUWB);
        check("jalr_reg_write", 32'(reg_write), 32'(1'b1));
        step();
        check_state("jalr_done", FETCH);

        // lui: zero + imm through EXECI-free path
        opcode = 7'b0110111;
        #1;
        check("lui_imm_src", 32'(imm_src), 32'(IMM_U));
        fetch_decode("lui");
        check_state("lui_state", LUI);
        check("lui_src_a", 32'(alu_src_a), 32'(2'b11));
        step();
        check_state("lui_aluwb", ALUWB);
        step();

        // sw, reset asserted during the MEMWRITE wait
        opcode = 7'b0100011;
        #1;
        check("sw_imm_src", 32'(imm_src), 32'(IMM_S));
        fetch_decode("sw");
        check_state("sw_memadr", MEMADR);
        step();
        check_state("sw_memwrite", MEMWRITE);
        check("sw_mem_write", 32'(mem_write), 32'(1'b1));
        check("sw_adr_src", 32'(adr_src), 32'(1'b1));
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        check_state("sw_rst_state", FETCH);
        check("sw_rst_mem_write", 32'(mem_write), 32'(1'b0));
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
